// File: rtl/vp_spec_controller.sv
// vp_spec_controller: one load value-prediction episode (snapshot, speculate, commit or recover).
// Optional VP_STATS_EN enables saturating episode counters (stats_event hooks under SIMULATION).
module vp_spec_controller #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_SPEC_CYCLES = 64,
    parameter int CNT_W           = $clog2(MAX_SPEC_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_miss,
    input  logic                  pred_valid,
    input  logic [DATA_WIDTH-1:0] pred_data,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  snap_req,
    input  logic                  snap_done,
    output logic                  recover_req,
    input  logic                  recover_done,
    output logic                  spec_valid,
    output logic [DATA_WIDTH-1:0] spec_value,
    output logic                  spec_active,
    output logic                  mem_stall,
    output logic                  commit,
    output logic                  flush_pipe,
    output logic [31:0]           stat_commits,
    output logic [31:0]           stat_mispredicts,
    output logic [31:0]           stat_timeouts
);
    typedef enum logic [1:0] {IDLE, SNAP, SPEC, RECOVER} state_t;
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(MAX_SPEC_CYCLES - 1);
    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_pred;
    logic [CNT_W-1:0]      r_timer;
    logic                  r_snap_req, r_mem_stall, r_spec_valid, r_spec_active, r_recover_req;
    logic                  r_commit, r_flush;
    logic                  w_commit, w_mispred, w_timeout;
    always_comb begin
        w_next    = r_state;
        w_commit  = 1'b0;
        w_mispred = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            IDLE:    w_next = (load_miss && pred_valid) ? SNAP : IDLE;
            SNAP:    w_next = fill_valid ? IDLE : (snap_done ? SPEC : SNAP);
            SPEC: begin
                // a fill in the timeout cycle is evaluated; the timeout only fires without one
                w_commit  = fill_valid && (fill_data == r_pred);
                w_mispred = fill_valid && (fill_data != r_pred);
                w_timeout = !fill_valid && (r_timer == TMAX);
                w_next    = w_commit ? IDLE : ((w_mispred || w_timeout) ? RECOVER : SPEC);
            end
            RECOVER: w_next = recover_done ? IDLE : RECOVER;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pred        <= '0;
            r_timer       <= '0;
            r_snap_req    <= 1'b0;
            r_mem_stall   <= 1'b0;
            r_spec_valid  <= 1'b0;
            r_spec_active <= 1'b0;
            r_recover_req <= 1'b0;
            r_commit      <= 1'b0;
            r_flush       <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_pred        <= (r_state == IDLE && load_miss && pred_valid) ? pred_data : r_pred;
            r_timer       <= (r_state == SPEC && w_next == SPEC) ? r_timer + 1'b1 : '0;
            r_snap_req    <= w_next == SNAP;
            r_mem_stall   <= w_next == SNAP;
            r_spec_valid  <= w_next == SPEC;
            r_spec_active <= (w_next == SPEC) || (w_next == RECOVER);
            r_recover_req <= w_next == RECOVER;
            r_commit      <= w_commit;
            r_flush       <= w_mispred || w_timeout;
        end
    end
    assign snap_req    = r_snap_req;
    assign mem_stall   = r_mem_stall;
    assign spec_valid  = r_spec_valid;
    assign spec_value  = r_pred;
    assign spec_active = r_spec_active;
    assign recover_req = r_recover_req;
    assign commit      = r_commit;
    assign flush_pipe  = r_flush;
`ifdef VP_STATS_EN
    logic [31:0] r_commits, r_mispredicts, r_timeouts;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commits     <= '0;
            r_mispredicts <= '0;
            r_timeouts    <= '0;
        end else begin
            r_commits     <= (w_commit && r_commits != '1) ? r_commits + 1'b1 : r_commits;
            r_mispredicts <= (w_mispred && r_mispredicts != '1) ? r_mispredicts + 1'b1 : r_mispredicts;
            r_timeouts    <= (w_timeout && r_timeouts != '1) ? r_timeouts + 1'b1 : r_timeouts;
        end
    end
`ifdef SIMULATION
    function automatic void stats_event(input string name);
        $display("stats_event %s", name);
    endfunction
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) stats_event("vp_commit");
        if (rst_n && w_mispred) stats_event("vp_mispredict");
        if (rst_n && w_timeout) stats_event("vp_timeout");
    end
`endif
    assign stat_commits     = r_commits;
    assign stat_mispredicts = r_mispredicts;
    assign stat_timeouts    = r_timeouts;
`else
    assign stat_commits     = '0;
    assign stat_mispredicts = '0;
    assign stat_timeouts    = '0;
`endif
endmodule

// File: tb/tb_vp_spec_controller.sv
// tb_vp_spec_controller: directed and randomized episodes checked against an episode-outcome model.
module tb_vp_spec_controller;
    localparam int DW   = 32;
    localparam int MAXC = 8;
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_SNAP   = 7'b1100000;
    localparam logic [6:0] O_SPEC   = 7'b0011000;
    localparam logic [6:0] O_REC    = 7'b0001100;
    localparam logic [6:0] O_FLUSH  = 7'b0000001;
    localparam logic [6:0] O_COMMIT = 7'b0000010;
    logic clk = 0, rst_n = 0;
    logic load_miss = 0, pred_valid = 0, fill_valid = 0, snap_done = 0, recover_done = 0;
    logic [DW-1:0] pred_data = '0, fill_data = '0;
    logic snap_req, recover_req, spec_valid, spec_active, mem_stall, commit, flush_pipe;
    logic [DW-1:0] spec_value;
    logic [31:0] stat_commits, stat_mispredicts, stat_timeouts;
    logic [6:0] obs;
    int n_cmp = 0, n_err = 0;
    int exp_commits = 0, exp_mis = 0, exp_to = 0;

    vp_spec_controller #(.DATA_WIDTH(DW), .MAX_SPEC_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .load_miss(load_miss), .pred_valid(pred_valid),
        .pred_data(pred_data), .fill_valid(fill_valid), .fill_data(fill_data),
        .snap_req(snap_req), .snap_done(snap_done), .recover_req(recover_req),
        .recover_done(recover_done), .spec_valid(spec_valid), .spec_value(spec_value),
        .spec_active(spec_active), .mem_stall(mem_stall), .commit(commit),
        .flush_pipe(flush_pipe), .stat_commits(stat_commits),
        .stat_mispredicts(stat_mispredicts), .stat_timeouts(stat_timeouts)
    );

    assign obs = {snap_req, mem_stall, spec_valid, spec_active, recover_req, commit, flush_pipe};
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        load_miss = 0; pred_valid = 0; fill_valid = 0; snap_done = 0; recover_done = 0;
    endtask

    function automatic logic [95:0] exp_stats();
`ifdef VP_STATS_EN
        return {32'(exp_commits), 32'(exp_mis), 32'(exp_to)};
`else
        return 96'd0;
`endif
    endfunction

    // Episode outcome from the rules alone: 0 abort, 1 commit, 2 mispredict, 3 timeout
    function automatic int outcome(int sd, int fe, int fk, bit match);
        if (fe >= 0 && fe <= sd) return 0;
        if (fk < 0 || fk >= MAXC) return 3;
        return match ? 1 : 2;
    endfunction

    task automatic episode(input string nm, input logic [DW-1:0] pred, input logic [DW-1:0] fdat,
                           input int sd, input int fe, input int fk, input int rd);
        int oc;
        int spec_len;
        oc = outcome(sd, fe, fk, pred == fdat);
        spec_len = (oc == 3) ? MAXC : fk + 1;
        load_miss = 1; pred_valid = 1; pred_data = pred;
        tick();
        clear_in();
        for (int i = 0; i <= sd; i++) begin
            n_cmp++;
            if (obs !== O_SNAP) begin
                n_err++;
                $display("FAIL %s snap[%0d]: got %b want %b", nm, i, obs, O_SNAP);
            end
            snap_done = (i == sd); fill_valid = (i == fe); fill_data = fdat;
            recover_done = 1'($urandom_range(0, 1)); load_miss = 1'($urandom_range(0, 1));
            pred_valid = 1; pred_data = $urandom;
            tick();
            clear_in();
            if (oc == 0 && i == fe) break;
        end
        if (oc != 0) begin
            for (int k = 0; k < spec_len; k++) begin
                n_cmp += 2;
                if (obs !== O_SPEC) begin
                    n_err++;
                    $display("FAIL %s spec[%0d]: got %b want %b", nm, k, obs, O_SPEC);
                end
                if (spec_value !== pred) begin
                    n_err++;
                    $display("FAIL %s spec_value[%0d]: got %h want %h", nm, k, spec_value, pred);
                end
                fill_valid = (k == fk); fill_data = fdat;
                load_miss = 1'($urandom_range(0, 1)); pred_valid = 1; pred_data = $urandom;
                snap_done = 1'($urandom_range(0, 1)); recover_done = 1'($urandom_range(0, 1));
                tick();
                clear_in();
            end
            if (oc == 1) begin
                exp_commits++;
                n_cmp++;
                if (obs !== O_COMMIT) begin
                    n_err++;
                    $display("FAIL %s commit: got %b want %b", nm, obs, O_COMMIT);
                end
            end else begin
                if (oc == 2) exp_mis++; else exp_to++;
                for (int r = 0; r <= rd; r++) begin
                    n_cmp++;
                    if (obs !== (r == 0 ? (O_REC | O_FLUSH) : O_REC)) begin
                        n_err++;
                        $display("FAIL %s recover[%0d]: got %b want %b", nm, r, obs,
                                 r == 0 ? (O_REC | O_FLUSH) : O_REC);
                    end
                    recover_done = (r == rd); snap_done = 1'($urandom_range(0, 1));
                    load_miss = 1'($urandom_range(0, 1)); pred_valid = 1;
                    tick();
                    clear_in();
                end
            end
        end
        if (oc != 1) begin
            n_cmp++;
            if (obs !== O_IDLE) begin
                n_err++;
                $display("FAIL %s idle: got %b want %b", nm, obs, O_IDLE);
            end
        end
        n_cmp++;
        if ({stat_commits, stat_mispredicts, stat_timeouts} !== exp_stats()) begin
            n_err++;
            $display("FAIL %s stats: got %0d/%0d/%0d want %h", nm, stat_commits,
                     stat_mispredicts, stat_timeouts, exp_stats());
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) tick();
        n_cmp++;
        if ({obs, spec_value} !== {O_IDLE, 32'd0}) begin
            n_err++;
            $display("FAIL reset outputs: got %b %h want 0", obs, spec_value);
        end
        n_cmp++;
        if ({stat_commits, stat_mispredicts, stat_timeouts} !== 96'd0) begin
            n_err++;
            $display("FAIL reset stats: got %0d/%0d/%0d want 0", stat_commits, stat_mispredicts, stat_timeouts);
        end
        rst_n = 1;
        tick();
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL reset release: got %b want %b", obs, O_IDLE);
        end
    endtask

    task automatic test_no_pred;
        for (int i = 0; i < 4; i++) begin
            load_miss = 1; pred_valid = 0; pred_data = $urandom;
            tick();
            n_cmp++;
            if (obs !== O_IDLE) begin
                n_err++;
                $display("FAIL no_pred[%0d]: got %b want %b", i, obs, O_IDLE);
            end
        end
        clear_in();
    endtask

    task automatic test_match;
        episode("match", 32'h1234, 32'h1234, 3, -1, 5, 0);
        tick();
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL match post: got %b want %b", obs, O_IDLE);
        end
    endtask

    task automatic test_mismatch;
        episode("mismatch", 32'hAAAA, 32'hBBBB, 1, -1, 2, 3);
        episode("mismatch_msb", 32'h0000_0001, 32'h8000_0001, 0, -1, 0, 1);
    endtask

    task automatic test_timeout;
        episode("timeout", 32'hCAFE_F00D, 32'h0, 2, -1, -1, 0);
        episode("timeout_fill_match", 32'h5555_0000, 32'h5555_0000, 1, -1, MAXC - 1, 0);
        episode("timeout_fill_miss", 32'h5555_0000, 32'h5555_0001, 1, -1, MAXC - 1, 2);
    endtask

    task automatic test_early_fill;
        episode("early_fill", 32'h1111, 32'h1111, 2, 0, -1, 0);
        episode("early_same_cycle", 32'h2222, 32'h2222, 2, 2, -1, 0);
        episode("early_first", 32'h3333, 32'h4444, 0, 0, -1, 0);
    endtask

    task automatic test_reset_mid_spec;
        load_miss = 1; pred_valid = 1; pred_data = 32'hDEAD_BEEF;
        tick();
        clear_in();
        snap_done = 1;
        tick();
        clear_in();
        tick();
        n_cmp++;
        if (obs !== O_SPEC) begin
            n_err++;
            $display("FAIL rst_mid pre: got %b want %b", obs, O_SPEC);
        end
        rst_n = 0; fill_valid = 1; fill_data = 32'hDEAD_BEEF;
        tick();
        rst_n = 1; clear_in();
        exp_commits = 0; exp_mis = 0; exp_to = 0;
        n_cmp++;
        if ({obs, spec_value} !== {O_IDLE, 32'd0}) begin
            n_err++;
            $display("FAIL rst_mid outputs: got %b %h want 0", obs, spec_value);
        end
        n_cmp++;
        if ({stat_commits, stat_mispredicts, stat_timeouts} !== 96'd0) begin
            n_err++;
            $display("FAIL rst_mid stats: got %0d/%0d/%0d want 0", stat_commits, stat_mispredicts, stat_timeouts);
        end
        tick();
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL rst_mid after: got %b want %b", obs, O_IDLE);
        end
    endtask

    task automatic test_back_to_back;
        episode("b2b_commit", 32'h0BAD_0001, 32'h0BAD_0001, 0, -1, 0, 0);
        episode("b2b_flush", 32'h0BAD_0002, 32'h0BAD_0003, 0, -1, 1, 0);
        episode("b2b_abort", 32'h0BAD_0004, 32'h0BAD_0004, 1, 1, -1, 0);
        episode("b2b_timeout", 32'h0BAD_0005, 32'h0, 0, -1, -1, 1);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] p, f;
            int sd, fe, fk, rd;
            p  = $urandom;
            f  = $urandom_range(0, 1) ? p : p ^ (32'd1 << $urandom_range(0, DW - 1));
            sd = $urandom_range(0, 3);
            fe = ($urandom_range(0, 3) == 0) ? $urandom_range(0, sd) : -1;
            fk = $urandom_range(0, MAXC + 1);
            fk = (fk >= MAXC) ? -1 : fk;
            rd = $urandom_range(0, 3);
            episode($sformatf("rand%0d", n), p, f, sd, fe, fk, rd);
            if ($urandom_range(0, 1)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_no_pred();
        test_match();
        test_mismatch();
        test_timeout();
        test_early_fill();
        test_reset_mid_spec();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vp_spec_controller.md
Name: vp_spec_controller

Overview:
- Sequences one load value-prediction episode for the MEM stage.
- On a D-cache load miss with a prediction available: requests a register snapshot, then releases the predicted value to the pipeline.
- Holds speculation until the D-cache fill returns, then either commits (value match) or drives snapshot recovery and pipeline flush (mismatch or timeout).
- Sits beside hazard_controller, between value_prediction, register_snapshot and the D-cache; at most one speculation in flight.

Parameters:
- DATA_WIDTH, 32, width of load data and predicted value.
- MAX_SPEC_CYCLES, 64, SPEC cycles allowed before forced recovery; legal range 2..1024.
- CNT_W, $clog2(MAX_SPEC_CYCLES), width of the speculation timer.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- load_miss  in  1  MEM-stage load missed in D-cache (level)
- pred_valid  in  1  predictor holds a value for this load
- pred_data  in  DATA_WIDTH  predicted load value
- fill_valid  in  1  D-cache refill data valid (1-cycle pulse)
- fill_data  in  DATA_WIDTH  refill data
- snap_req  out  1  take register snapshot
- snap_done  in  1  snapshot captured (pulse)
- recover_req  out  1  restore registers from snapshot
- recover_done  in  1  restore complete (pulse)
- spec_valid  out  1  spec_value may be consumed by the pipeline
- spec_value  out  DATA_WIDTH  latched predicted value
- spec_active  out  1  speculative instructions in flight
- mem_stall  out  1  hold MEM while snapshot pending
- commit  out  1  speculation verified (1-cycle pulse)
- flush_pipe  out  1  squash younger instructions (1-cycle pulse)
- stat_commits / stat_mispredicts / stat_timeouts  out  32 each  episode counters

Behaviour:
- Reset: state IDLE; all 1-bit outputs 0; spec_value 0; timer 0; stat_* 0. Reset in any state aborts the episode with no commit and no flush.
- IDLE:
  - load_miss & pred_valid: latch pred_data into pred_reg; next SNAP.
  - load_miss & ~pred_valid: stay IDLE, no outputs; the normal miss stall path handles it.
- SNAP:
  - snap_req=1, mem_stall=1.
  - snap_done: next SPEC; spec_valid=1 from the first SPEC cycle; timer cleared.
  - fill_valid before snap_done: abort to IDLE. No commit, no flush, spec_valid never raised.
  - fill_valid and snap_done in the same cycle: treated as abort (fill wins).
- SPEC:
  - spec_active=1, spec_valid=1, spec_value=pred_reg. Timer increments each cycle.
  - fill_valid & fill_data==pred_reg: commit=1 that cycle; next IDLE.
  - fill_valid & mismatch: flush_pipe=1 that cycle; next RECOVER.
  - Timer == MAX_SPEC_CYCLES-1 without fill: flush_pipe=1; next RECOVER (timeout).
  - fill_valid in the timeout cycle: the fill is evaluated; timeout ignored.
- RECOVER:
  - recover_req=1, spec_active=1, spec_valid=0.
  - recover_done: next IDLE. recover_done arriving in the first RECOVER cycle is legal.
- Other inputs:
  - load_miss outside IDLE is ignored (no queueing).
  - snap_done or recover_done outside its state is ignored.
- Output timing: spec_value is stable for the whole of SPEC. All outputs are Moore-decoded from state, except commit and flush_pipe, which are registered pulses asserted the cycle after the deciding input.
- Latency: load_miss to snap_req 1 cycle; snap_done to spec_valid 1 cycle; fill to commit or flush 1 cycle.
- Widths: comparison is full DATA_WIDTH. The timer is CNT_W bits and never wraps (bounded by the timeout).

Optional Feature:
- VP_STATS_EN defined: stat_commits, stat_mispredicts and stat_timeouts each count the matching episode end. Each counter is 32-bit, saturates at 0xFFFFFFFF and is reset to 0. Under SIMULATION, each end also calls stats_event("vp_commit"), stats_event("vp_mispredict") or stats_event("vp_timeout").
- VP_STATS_EN undefined: the three ports are tied to 0; no counters or stats calls are generated.

Test Plan:
- Match: load_miss+pred_valid, pred_data=0x1234; snap_done 3 cycles later; fill 0x1234 after 10 cycles -> snap_req 1 cycle after miss, spec_valid with 0x1234, commit pulse, no flush, back to IDLE.
- Mismatch: pred 0xAAAA, fill 0xBBBB -> flush_pipe pulse, recover_req high until recover_done, then IDLE. With VP_STATS_EN, stat_mispredicts=1.
- Timeout: MAX_SPEC_CYCLES=8, no fill -> flush_pipe after 8 SPEC cycles, RECOVER, stat_timeouts=1. A fill arriving in the timeout cycle with a match -> commit instead.
- Early fill: fill_valid during SNAP, including the same cycle as snap_done -> IDLE, spec_valid, commit and flush all remain 0.
- No prediction / busy: load_miss with pred_valid=0 -> no outputs. A second load_miss during SPEC -> ignored, pred_reg unchanged.
- Reset mid-SPEC: rst_n low for 1 cycle -> all outputs 0 next cycle, state IDLE, stat counters 0.
